// File: rtl/sar_ctrl.sv
// SAR ADC sequencer: sample, then MSB-first binary search on the comparator.
// Define SAR_DECISION_ERR_EN to add the sticky invalid-decision flag on err.
module sar_ctrl #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             comp_p,
  input  logic             comp_n,
  output logic             comp_clk,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic [NBITS-1:0] data_out,
`ifdef SAR_DECISION_ERR_EN
  output logic             valid,
  output logic             err
`else
  output logic             valid
`endif
);

  localparam int MAXC = (SAMPLE_CYCLES > SETTLE_CYCLES)
                      ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CW-1:0] SAMP_LD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETL_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] MSB_IDX = BW'(NBITS - 1);
  localparam logic [NBITS-1:0] ONE  = NBITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_STROBE,
    S_DECIDE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] code_q, code_d;
  logic             comp_clk_q, comp_clk_d;
  logic             sample_q, sample_d;
  logic [NBITS-1:0] dac_code_q, dac_code_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;

  logic [NBITS-1:0] mask;
  logic [NBITS-1:0] code_nx;
  logic             keep;

`ifdef SAR_DECISION_ERR_EN
  logic errf_q, errf_d;
  logic err_q, err_d;
  logic invalid;
  assign invalid = (comp_p == comp_n);
  assign keep    = comp_p & ~comp_n;
`else
  logic unused_comp_n;
  assign unused_comp_n = comp_n;
  assign keep          = comp_p;
`endif

  assign mask    = ONE << bit_q;
  assign code_nx = keep ? (code_q | mask) : code_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    code_d     = code_q;
    comp_clk_d = 1'b0;
    sample_d   = sample_q;
    dac_code_d = dac_code_q;
    busy_d     = busy_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
`ifdef SAR_DECISION_ERR_EN
    errf_d     = errf_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_SAMPLE;
          cnt_d      = SAMP_LD;
          bit_d      = MSB_IDX;
          code_d     = '0;
          sample_d   = 1'b1;
          busy_d     = 1'b1;
          dac_code_d = '0;
`ifdef SAR_DECISION_ERR_EN
          errf_d     = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == '0) begin
          state_d    = S_SETTLE;
          cnt_d      = SETL_LD;
          sample_d   = 1'b0;
          dac_code_d = code_q | mask;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d    = S_STROBE;
          comp_clk_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        code_d = code_nx;
`ifdef SAR_DECISION_ERR_EN
        errf_d = errf_q | invalid;
`endif
        if (bit_q != '0) begin
          state_d    = S_SETTLE;
          cnt_d      = SETL_LD;
          bit_d      = bit_q - BW'(1);
          dac_code_d = code_nx | (mask >> 1);
        end else begin
          state_d    = S_DONE;
          dac_code_d = code_nx;
          data_out_d = code_nx;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
`ifdef SAR_DECISION_ERR_EN
          err_d      = errf_q | invalid;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= MSB_IDX;
      code_q     <= '0;
      comp_clk_q <= 1'b0;
      sample_q   <= 1'b0;
      dac_code_q <= '0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      comp_clk_q <= comp_clk_d;
      sample_q   <= sample_d;
      dac_code_q <= dac_code_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

`ifdef SAR_DECISION_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      errf_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      errf_q <= errf_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign comp_clk = comp_clk_q;
  assign sample   = sample_q;
  assign dac_code = dac_code_q;
  assign busy     = busy_q;
  assign data_out = data_out_q;
  assign valid    = valid_q;

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
- Successive-approximation sequencer for the differential strobed comparator (`comp`) in the SAR ADC.
- Runs a sample phase, then performs NBITS binary-search trials MSB first.
- For each trial it drives the capacitive-DAC code, fires the comparator clock and keeps or clears the trial bit from the comparator outputs.
- Publishes the final code with a one-cycle valid pulse. Sits between the ADC front end (`comp`, CDAC switches) and the digital readout.

Parameters:
- NBITS, 8: conversion resolution; width of dac_code and data_out.
- SAMPLE_CYCLES, 2: cycles the sample switch is held closed; minimum 1.
- SETTLE_CYCLES, 1: DAC settle cycles before each comparator strobe; minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  conversion request; sampled only in IDLE or DONE.
- comp_p  input  1  comparator positive output (`comp` vout_p).
- comp_n  input  1  comparator negative output (`comp` vout_n).
- comp_clk  output  1  comparator clock (`comp` clk); high for exactly one cycle per trial.
- sample  output  1  sample-switch enable; high during SAMPLE.
- dac_code  output  NBITS  CDAC switch code.
- busy  output  1  high in SAMPLE, SETTLE, STROBE and DECIDE.
- data_out  output  NBITS  last completed conversion result; held until the next DONE.
- valid  output  1  one-cycle pulse when data_out updates.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active low, with clk and rst_n named as in the codebase. All outputs are registered.
- Reset values:
  - FSM = IDLE.
  - comp_clk, sample, busy, valid = 0.
  - dac_code, data_out = 0.
  - Bit index = NBITS-1.
- FSM states and transitions:
  - IDLE: start=1 -> SAMPLE; clears working code and bit index = NBITS-1.
  - SAMPLE: sample=1, dac_code=0, held SAMPLE_CYCLES cycles -> SETTLE.
  - SETTLE: dac_code = decided upper bits, trial bit[i]=1, lower bits 0; held SETTLE_CYCLES cycles -> STROBE.
  - STROBE: comp_clk=1 for one cycle; dac_code unchanged -> DECIDE.
  - DECIDE: comp_clk=0; samples comp_p/comp_n.
    - comp_p=1, comp_n=0: keep bit[i]=1.
    - comp_p=0, comp_n=1: clear bit[i].
    - comp_p==comp_n (invalid): clear bit[i].
    - i>0: i<=i-1 -> SETTLE. i==0 -> DONE.
  - DONE: data_out <= working code; valid=1 for this cycle only; busy=0; dac_code holds the final code. start=1 -> SAMPLE (back-to-back conversion), else -> IDLE.
- Latency: valid is visible after edge SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+2), counted from the edge that samples start. With defaults this is 26.
- start handling: ignored in every state except IDLE and DONE. No queuing.
- Reset mid-conversion: on the next edge the block is in full reset state; no valid pulse; data_out is cleared to 0.
- Counters: sample/settle counter width is clog2(max(SAMPLE_CYCLES, SETTLE_CYCLES)+1). The counter reloads on each state entry and does not wrap.

Optional Feature:
- Macro: SAR_DECISION_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - Any invalid decision (comp_p==comp_n in DECIDE) sets an internal sticky flag, which is cleared on entry to SAMPLE.
  - err is updated alongside data_out in DONE and held until the next DONE.
  - Bit resolution is still "clear".
- Undefined:
  - No err port.
  - Only comp_p is used: comp_p=1 keeps the bit, else the bit is cleared. comp_n is unused.

Test Plan:
- Behavioural comparator model with vin code 0xA5: pulse start for 1 cycle -> valid pulse at edge 26, data_out=0xA5. Exactly 8 comp_clk pulses; dac_code trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Endpoint codes: vin=0x00 -> data_out=0x00; vin=0xFF -> data_out=0xFF. sample high for exactly 2 cycles in each conversion.
- rst_n=0 for 1 cycle during bit-4 STROBE:
  - Next cycle all outputs are at reset values.
  - No valid pulse follows.
  - A fresh start with vin 0x3C gives data_out=0x3C.
- start held high continuously with vin 0x5A:
  - start pulses during busy are ignored.
  - Back-to-back conversions give valid every 27 cycles.
  - data_out=0x5A each time.
- With SAR_DECISION_ERR_EN, force comp_p=comp_n=1 in bit-3 DECIDE with vin 0xFF:
  - data_out=0xF7, err=1.
  - Next clean conversion gives err=0.
- Without SAR_DECISION_ERR_EN: same stimulus -> data_out=0xFF (comp_p=1 decides), and no err port is present.
